// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// State encodings are fixed so they stay stable in waveforms and debug tooling.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_IBUSY = 2'b01,
    ARB_DBUSY = 2'b10,
    ARB_IDROP = 2'b11
  } arb_state_e;

  localparam int unsigned ARB_MAX_DATA_WINS_DEF = 4;
  localparam int unsigned ARB_WIN_CNT_W         = 4;
  localparam int unsigned ARB_STAT_W            = 16;

  function automatic logic [ARB_STAT_W-1:0] arb_sat_inc(input logic [ARB_STAT_W-1:0] v);
    return (v == {ARB_STAT_W{1'b1}}) ? v : v + ARB_STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = ARB_MAX_DATA_WINS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit_c
);

  logic [ARB_WIN_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {ARB_WIN_CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + ARB_WIN_CNT_W'(1);
    end
  end

  assign o_at_limit_c = (32'(r_cnt) >= 32'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared stalling memory between fetch and the memory stage.
// Optional grant/conflict statistics are enabled with MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned MAX_DATA_WINS = ARB_MAX_DATA_WINS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic              IFlush,
  output logic              IStall,
  output logic              IDone,
  output logic [DATA_W-1:0] IData,
  input  logic              DRd,
  input  logic              DWr,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DStall,
  output logic              DDone,
  output logic [DATA_W-1:0] DRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRd,
  output logic              MemWr,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemDone,
  input  logic              MemStall
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [ARB_STAT_W-1:0] IGrantCnt,
  output logic [ARB_STAT_W-1:0] DGrantCnt,
  output logic [ARB_STAT_W-1:0] ConflictCnt
`endif
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              w_d_pend;
  logic              w_d_grant;
  logic              w_i_grant;
  logic              w_idone_nxt;
  logic              w_ddone_nxt;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic              w_at_limit;
  logic              r_idone;
  logic              r_ddone;
  logic              r_is_wr;
  logic [DATA_W-1:0] r_idata;
  logic [DATA_W-1:0] r_drdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  assign w_d_pend = DRd | DWr;

  arb_starve_cnt #(.LIMIT(MAX_DATA_WINS)) u_starve_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_cnt_inc),
    .i_clr        (w_cnt_clr),
    .o_at_limit_c (w_at_limit)
  );

  // Next-state and grant decode; data wins unless fetch has waited too long.
  always_comb begin
    w_state_nxt = r_state;
    w_d_grant   = 1'b0;
    w_i_grant   = 1'b0;
    w_idone_nxt = 1'b0;
    w_ddone_nxt = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (!rst && !MemStall) begin
          if (w_d_pend && (!IReq || !w_at_limit)) begin
            w_d_grant   = 1'b1;
            w_state_nxt = ARB_DBUSY;
            w_cnt_inc   = IReq;
            w_cnt_clr   = ~IReq;
          end else if (IReq) begin
            w_i_grant   = 1'b1;
            w_state_nxt = ARB_IBUSY;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      ARB_IBUSY: begin
        if (IFlush) begin
          w_state_nxt = MemDone ? ARB_IDLE : ARB_IDROP;
        end else if (MemDone) begin
          w_idone_nxt = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_DBUSY: begin
        if (MemDone) begin
          w_ddone_nxt = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_IDROP: begin
        if (MemDone) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_idone     <= 1'b0;
      r_ddone     <= 1'b0;
      r_is_wr     <= 1'b0;
      r_idata     <= '0;
      r_drdata    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idone <= w_idone_nxt;
      r_ddone <= w_ddone_nxt;
      if (w_idone_nxt) begin
        r_idata <= MemRData;
      end
      if (w_ddone_nxt && !r_is_wr) begin
        r_drdata <= MemRData;
      end
      if (w_d_grant) begin
        r_mem_addr  <= DAddr;
        r_mem_wdata <= DWData;
        r_is_wr     <= DWr;
      end else if (w_i_grant) begin
        r_mem_addr <= IAddr;
      end
    end
  end

  // Strobe cycle presents the granted request directly; busy states hold the latched copy.
  assign MemAddr  = (r_state == ARB_IDLE) ? (w_d_grant ? DAddr : IAddr) : r_mem_addr;
  assign MemWData = (r_state == ARB_IDLE) ? DWData : r_mem_wdata;
  assign MemRd    = w_i_grant | (w_d_grant & ~DWr);
  assign MemWr    = w_d_grant & DWr;

  assign IDone  = r_idone;
  assign IData  = r_idata;
  assign DDone  = r_ddone;
  assign DRData = r_drdata;
  assign IStall = ~rst & IReq & ~r_idone;
  assign DStall = ~rst & w_d_pend & ~r_ddone;

`ifdef MEM_ARB_STATS_EN
  logic [ARB_STAT_W-1:0] r_igrant_cnt;
  logic [ARB_STAT_W-1:0] r_dgrant_cnt;
  logic [ARB_STAT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_igrant_cnt   <= '0;
      r_dgrant_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_i_grant) begin
        r_igrant_cnt <= arb_sat_inc(r_igrant_cnt);
      end
      if (w_d_grant) begin
        r_dgrant_cnt <= arb_sat_inc(r_dgrant_cnt);
      end
      if ((r_state == ARB_IDLE) && IReq && w_d_pend) begin
        r_conflict_cnt <= arb_sat_inc(r_conflict_cnt);
      end
    end
  end

  assign IGrantCnt   = r_igrant_cnt;
  assign DGrantCnt   = r_dgrant_cnt;
  assign ConflictCnt = r_conflict_cnt;
`endif

endmodule
